// File: rtl/cam_stream_pkg.sv
// Shared types and helpers for the camera snapshot/stream path.
// Build macro CAM_STREAM_SWAP_RB_EN: when defined, rgb565_pack swaps red and blue.
package cam_stream_pkg;

  localparam int unsigned IMG_COLS_DEF = 80;
  localparam int unsigned IMG_ROWS_DEF = 60;
  localparam int unsigned ADDR_W_DEF   = 13;

  localparam int unsigned RGB565_W = 16;
  localparam int unsigned PIX_X_W  = 7;
  localparam int unsigned PIX_Y_W  = 6;

  typedef enum logic [1:0] {
    ST_LIVE,
    ST_SETTLE,
    ST_STREAM,
    ST_DRAIN
  } stream_state_t;

  typedef struct packed {
    logic [RGB565_W-1:0] data;
    logic [PIX_X_W-1:0]  x;
    logic [PIX_Y_W-1:0]  y;
    logic                sof;
    logic                eol;
    logic                eof;
  } pix_t;

  // The sensor module on some boards swaps red and blue; the macro compensates.
  function automatic logic [RGB565_W-1:0] rgb565_pack(input logic [4:0] r5,
                                                      input logic [5:0] g6,
                                                      input logic [4:0] b5);
`ifdef CAM_STREAM_SWAP_RB_EN
    return {b5, g6, r5};
`else
    return {r5, g6, b5};
`endif
  endfunction

endpackage

// File: rtl/cam_frame_stream_if.sv
// Valid/ready pixel stream carrying RGB565 data with x/y and frame/line markers.
interface cam_frame_stream_if;
  import cam_stream_pkg::*;

  logic                valid;
  logic                ready;
  logic [RGB565_W-1:0] data;
  logic [PIX_X_W-1:0]  x;
  logic [PIX_Y_W-1:0]  y;
  logic                sof;
  logic                eol;
  logic                eof;

  modport master (output valid, data, x, y, sof, eol, eof, input ready);
  modport slave  (input valid, data, x, y, sof, eol, eof, output ready);
endinterface

// File: rtl/pixel_skid_buf.sv
// Two-entry valid/ready buffer with a registered output stage and one skid slot.
module pixel_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         oclk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic         r_svalid;
  logic [W-1:0] r_data;
  logic [W-1:0] r_sdata;

  always_ff @(posedge oclk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_svalid <= 1'b0;
      r_data   <= '0;
      r_sdata  <= '0;
    end else if (!r_valid || i_ready) begin
      if (r_svalid) begin
        r_data   <= r_sdata;
        r_valid  <= 1'b1;
        r_svalid <= i_valid;
        if (i_valid) r_sdata <= i_data;
      end else begin
        r_valid <= i_valid;
        if (i_valid) r_data <= i_data;
      end
    end else if (i_valid) begin
      // Output is stalled: park the in-flight word
      r_sdata  <= i_data;
      r_svalid <= 1'b1;
    end
  end

  assign o_ready = !r_svalid;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cam_frame_stream.sv
// Snapshot-and-stream controller: gates capture writes, settles N frames, then streams the frozen buffer.
// Build macro CAM_STREAM_SWAP_RB_EN selects {b,g,r} output ordering instead of {r,g,b}.
module cam_frame_stream
  import cam_stream_pkg::*;
#(
  parameter int unsigned IMG_COLS      = IMG_COLS_DEF,
  parameter int unsigned IMG_ROWS      = IMG_ROWS_DEF,
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned R_W           = 5,
  parameter int unsigned G_W           = 5,
  parameter int unsigned B_W           = 6,
  parameter int unsigned SETTLE_FRAMES = 4,
  parameter int unsigned CONTINUOUS    = 0
) (
  input  logic                   oclk,
  input  logic                   rst,
  input  logic                   i_cap_we_in,
  input  logic                   i_cap_frame_end,
  input  logic                   i_stop,
  input  logic                   i_snap_req,
  output logic                   o_cap_we_out,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic [R_W+G_W+B_W-1:0] i_rd_data,
  cam_frame_stream_if.master     o_pix,
  output logic                   o_busy,
  output logic [7:0]             o_frame_cnt
);

  localparam int unsigned NPIX = IMG_COLS * IMG_ROWS;
  localparam int unsigned PIX_W = $bits(pix_t);
  localparam logic [ADDR_W-1:0]  ADDR_LAST   = ADDR_W'(NPIX - 1);
  localparam logic [PIX_X_W-1:0] X_LAST      = PIX_X_W'(IMG_COLS - 1);
  localparam logic [PIX_Y_W-1:0] Y_LAST      = PIX_Y_W'(IMG_ROWS - 1);
  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

  stream_state_t       r_state;
  logic                r_cap_we;
  logic                r_busy;
  logic [7:0]          r_frame_cnt;
  logic [7:0]          r_settle;
  logic [ADDR_W-1:0]   r_addr;
  logic [PIX_X_W-1:0]  r_x;
  logic [PIX_Y_W-1:0]  r_y;
  logic                r_pend;
  logic [PIX_X_W-1:0]  r_pend_x;
  logic [PIX_Y_W-1:0]  r_pend_y;

  logic [R_W-1:0] w_r;
  logic [G_W-1:0] w_g;
  logic [B_W-1:0] w_b;
  logic [5:0]     w_g6;
  logic           w_unused;
  pix_t           w_in;
  pix_t           w_out;
  logic           w_out_valid;
  logic           w_skid_rdy;
  logic           w_pop;
  logic [1:0]     w_inflight;
  logic           w_issue;

  assign {w_r, w_g, w_b} = i_rd_data;
  assign w_unused = ^i_rd_data;

  if (G_W == 5) begin : g_widen
    assign w_g6 = {w_g, w_g[G_W-1]};
  end else begin : g_trim
    assign w_g6 = w_g[G_W-1 -: 6];
  end

  // Payload for the read returning this cycle; flags derive from its coordinates
  always_comb begin
    w_in      = '0;
    w_in.data = rgb565_pack(w_r[R_W-1 -: 5], w_g6, w_b[B_W-1 -: 5]);
    w_in.x    = r_pend_x;
    w_in.y    = r_pend_y;
    w_in.sof  = (r_pend_x == '0) && (r_pend_y == '0);
    w_in.eol  = (r_pend_x == X_LAST);
    w_in.eof  = w_in.eol && (r_pend_y == Y_LAST);
  end

  pixel_skid_buf #(.W(PIX_W)) u_skid (
    .oclk   (oclk),
    .rst    (rst),
    .i_valid(r_pend),
    .o_ready(w_skid_rdy),
    .i_data (w_in),
    .o_valid(w_out_valid),
    .i_ready(o_pix.ready),
    .o_data (w_out)
  );

  // Buffered words plus the read in flight, less the one leaving now, must stay below two
  assign w_pop      = w_out_valid & o_pix.ready;
  assign w_inflight = 2'(w_out_valid) + 2'(!w_skid_rdy) + 2'(r_pend) - 2'(w_pop);
  assign w_issue    = (r_state == ST_STREAM) && (w_inflight < 2'd2);

  always_ff @(posedge oclk) begin
    if (rst) begin
      r_state     <= ST_LIVE;
      r_cap_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_settle    <= '0;
      r_addr      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_pend      <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
    end else begin
      r_pend <= w_issue;
      if (i_cap_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_pend_x <= r_x;
        r_pend_y <= r_y;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + PIX_Y_W'(1);
        end else begin
          r_x <= r_x + PIX_X_W'(1);
        end
      end
      case (r_state)
        ST_LIVE: begin
          r_cap_we <= i_cap_we_in & ~i_stop;
          if (i_snap_req) begin
            r_state  <= ST_SETTLE;
            r_settle <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (i_cap_frame_end && (r_settle == SETTLE_LAST)) begin
            r_state  <= ST_STREAM;
            r_cap_we <= 1'b0;
            r_addr   <= '0;
            r_x      <= '0;
            r_y      <= '0;
          end else begin
            r_cap_we <= i_cap_we_in & ~i_stop;
            if (i_cap_frame_end) r_settle <= r_settle + 8'd1;
          end
        end
        ST_STREAM: begin
          r_cap_we <= 1'b0;
          if (w_issue && (r_addr == ADDR_LAST)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_cap_we <= 1'b0;
          if (w_pop && w_out.eof) begin
            if (CONTINUOUS != 0) begin
              r_state  <= ST_SETTLE;
              r_settle <= '0;
            end else begin
              r_state <= ST_LIVE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_LIVE;
      endcase
    end
  end

  assign o_cap_we_out = r_cap_we;
  assign o_rd_addr    = r_addr;
  assign o_busy       = r_busy;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_pix.valid  = w_out_valid;
  assign o_pix.data   = w_out.data;
  assign o_pix.x      = w_out.x;
  assign o_pix.y      = w_out.y;
  assign o_pix.sof    = w_out.sof;
  assign o_pix.eol    = w_out.eol;
  assign o_pix.eof    = w_out.eof;

endmodule

// File: tb/tb_cam_frame_stream.sv
// Self-checking bench for cam_frame_stream with a behavioural frame/pixel reference model.
module tb_cam_frame_stream;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int NPIX = COLS * ROWS;
`ifdef CAM_STREAM_SWAP_RB_EN
  localparam logic [15:0] EXP_PIX6 = 16'h0050;
`else
  localparam logic [15:0] EXP_PIX6 = 16'h8040;
`endif

  logic        oclk;
  logic        rst;
  logic        cap_we_in;
  logic        cap_frame_end;
  logic        stop;
  logic        snap_req;
  logic        cap_we_out;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic [7:0]  frame_cnt;

  logic [15:0] mem [0:8191];
  logic [15:0] rx_data [0:NPIX-1];

  int n_tests;
  int n_fail;
  int exp_fc;

  cam_frame_stream_if pix ();

  cam_frame_stream dut (
    .oclk           (oclk),
    .rst            (rst),
    .i_cap_we_in    (cap_we_in),
    .i_cap_frame_end(cap_frame_end),
    .i_stop         (stop),
    .i_snap_req     (snap_req),
    .o_cap_we_out   (cap_we_out),
    .o_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_pix          (pix),
    .o_busy         (busy),
    .o_frame_cnt    (frame_cnt)
  );

  initial oclk = 1'b0;
  always #5 oclk = ~oclk;

  // Frame buffer port B: one-cycle read latency
  always @(posedge oclk) rd_data <= mem[rd_addr];

  task automatic tick();
    @(posedge oclk);
    #1;
  endtask

  task automatic pulse_frame_end();
    cap_frame_end = 1'b1;
    tick();
    cap_frame_end = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic snapshot();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    for (int f = 0; f < 4; f++) begin
      repeat (3) tick();
      pulse_frame_end();
    end
  endtask

  // Expected pixel k, from the buffer word via plain arithmetic: {data, x, y, sof, eol, eof}
  function automatic logic [31:0] exp_pix(input int k);
    int w, r5, g5, g6, b5, d, x, y;
    w  = int'(mem[k]);
    r5 = w / 2048;
    g5 = (w / 64) % 32;
    g6 = g5 * 2 + g5 / 16;
    b5 = (w % 64) / 2;
`ifdef CAM_STREAM_SWAP_RB_EN
    d  = b5 * 2048 + g6 * 32 + r5;
`else
    d  = r5 * 2048 + g6 * 32 + b5;
`endif
    x  = k % COLS;
    y  = k / COLS;
    return {16'(d), 7'(x), 6'(y), (k == 0), (x == COLS - 1), (k == NPIX - 1)};
  endfunction

  task automatic run_frame(input int pct, input int stop_at,
                           output int n_rx, output int n_cyc,
                           output int first_cyc, output int n_eol);
    logic [31:0] act, expv, held_v;
    bit          held;
    n_rx = 0; n_cyc = 0; first_cyc = -1; n_eol = 0; held = 0; held_v = '0;
    while (n_rx < stop_at && n_cyc < 20000) begin
      pix.ready = ($urandom_range(99) < pct);
      act = {pix.data, pix.x, pix.y, pix.sof, pix.eol, pix.eof};
      if (held) begin
        n_tests++;
        if ({pix.valid, act} !== {1'b1, held_v}) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d got v=%b %h exp v=1 %h", n_cyc, pix.valid, act, held_v);
        end
      end
      held = 0;
      if (pix.valid === 1'b1) begin
        if (pix.ready) begin
          expv = exp_pix(n_rx);
          n_tests++;
          if (act !== expv) begin
            n_fail++;
            $display("FAIL pixel[%0d] got %h exp %h", n_rx, act, expv);
          end
          rx_data[n_rx] = pix.data;
          if (pix.eol === 1'b1) n_eol++;
          if (first_cyc < 0) first_cyc = n_cyc;
          n_rx++;
        end else begin
          held   = 1;
          held_v = act;
        end
      end
      tick();
      n_cyc++;
    end
    pix.ready = 1'b0;
    n_tests++;
    if (n_rx < stop_at) begin
      n_fail++;
      $display("FAIL stream_timeout got %0d pixels exp %0d", n_rx, stop_at);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_fc = 0;
    repeat (4) tick();
    n_tests++;
    if ({cap_we_out, rd_addr, busy, frame_cnt} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got we=%b addr=%0d busy=%b fc=%0d exp all 0", cap_we_out, rd_addr, busy, frame_cnt);
    end
    n_tests++;
    if ({pix.valid, pix.data, pix.x, pix.y, pix.sof, pix.eol, pix.eof} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_stream got v=%b d=%h x=%0d y=%0d flags=%b%b%b exp all 0",
               pix.valid, pix.data, pix.x, pix.y, pix.sof, pix.eol, pix.eof);
    end
  endtask

  task automatic test_cap_gating();
    logic exp_we;
    for (int i = 0; i < 32; i++) begin
      cap_we_in = 1'($urandom);
      stop      = ($urandom_range(3) == 0);
      if (i == 0) begin cap_we_in = 1'b1; stop = 1'b1; end
      if (i == 1) begin cap_we_in = 1'b1; stop = 1'b0; end
      exp_we = cap_we_in & ~stop;
      tick();
      n_tests++;
      if (cap_we_out !== exp_we) begin
        n_fail++;
        $display("FAIL cap_gate[%0d] got %b exp %b", i, cap_we_out, exp_we);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_frame_cnt_wrap();
    cap_frame_end = 1'b1;
    repeat (300) tick();
    cap_frame_end = 1'b0;
    exp_fc = (exp_fc + 300) % 256;
    n_tests++;
    if (frame_cnt !== 8'(exp_fc) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_cnt_wrap got %0d busy=%b exp %0d busy=0", frame_cnt, busy, exp_fc);
    end
  endtask

  task automatic test_snapshot_stream();
    int   n_rx, n_cyc, first_cyc, n_eol;
    logic exp_we;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    cap_we_in = 1'b1;
    stop      = 1'b0;
    snap_req  = 1'b1;
    tick();
    snap_req  = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_settle got %b exp 1", busy);
    end
    for (int f = 1; f <= 4; f++) begin
      tick();
      if (f == 2) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if (cap_we_out !== 1'b0) begin
          n_fail++;
          $display("FAIL stop_in_settle got %b exp 0", cap_we_out);
        end
      end
      pulse_frame_end();
      exp_we = (f < 4);
      n_tests++;
      if (cap_we_out !== exp_we) begin
        n_fail++;
        $display("FAIL settle_we frame %0d got %b exp %b", f, cap_we_out, exp_we);
      end
    end
    n_tests++;
    if ({rd_addr, pix.valid} !== 14'd0) begin
      n_fail++;
      $display("FAIL stream_entry got addr=%0d v=%b exp addr=0 v=0", rd_addr, pix.valid);
    end
    run_frame(100, NPIX, n_rx, n_cyc, first_cyc, n_eol);
    n_tests++;
    if (first_cyc !== 2) begin
      n_fail++;
      $display("FAIL first_valid_latency got %0d exp 2", first_cyc);
    end
    n_tests++;
    if (n_cyc !== NPIX + 2) begin
      n_fail++;
      $display("FAIL frame_cycles got %0d exp %0d", n_cyc, NPIX + 2);
    end
    n_tests++;
    if (n_eol !== ROWS) begin
      n_fail++;
      $display("FAIL eol_count got %0d exp %0d", n_eol, ROWS);
    end
    n_tests++;
    if ({busy, pix.valid, frame_cnt} !== {2'b00, 8'(exp_fc)}) begin
      n_fail++;
      $display("FAIL after_frame got busy=%b v=%b fc=%0d exp busy=0 v=0 fc=%0d", busy, pix.valid, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_random_ready();
    int n_rx, n_cyc, first_cyc, n_eol;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hFFFF;
    mem[6] = 16'b10000_00001_000001;
    snapshot();
    run_frame(50, NPIX, n_rx, n_cyc, first_cyc, n_eol);
    n_tests++;
    if (rx_data[5] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL conv_white got %h exp ffff", rx_data[5]);
    end
    n_tests++;
    if (rx_data[6] !== EXP_PIX6) begin
      n_fail++;
      $display("FAIL conv_pattern got %h exp %h", rx_data[6], EXP_PIX6);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_random got %b exp 0", busy);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    int n_rx, n_cyc, first_cyc, n_eol;
    cap_we_in     = 1'b1;
    snap_req      = 1'b1;
    cap_frame_end = 1'b1;
    tick();
    snap_req      = 1'b0;
    cap_frame_end = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
    for (int f = 0; f < 3; f++) begin
      repeat (2) tick();
      pulse_frame_end();
    end
    repeat (3) tick();
    n_tests++;
    if ({cap_we_out, busy, pix.valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL same_cycle_snap got we=%b busy=%b v=%b exp we=1 busy=1 v=0", cap_we_out, busy, pix.valid);
    end
    pulse_frame_end();
    n_tests++;
    if (cap_we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_4th got %b exp 0", cap_we_out);
    end
    run_frame(100, 1000, n_rx, n_cyc, first_cyc, n_eol);
    rst = 1'b1;
    tick();
    exp_fc = 0;
    n_tests++;
    if ({pix.valid, busy, cap_we_out, rd_addr, frame_cnt} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mid_stream got v=%b busy=%b we=%b addr=%0d fc=%0d exp all 0",
               pix.valid, busy, cap_we_out, rd_addr, frame_cnt);
    end
    rst = 1'b0;
    tick();
    snapshot();
    run_frame(100, NPIX, n_rx, n_cyc, first_cyc, n_eol);
    n_tests++;
    if (first_cyc !== 2 || n_cyc !== NPIX + 2) begin
      n_fail++;
      $display("FAIL restart_frame got first=%0d cycles=%0d exp first=2 cycles=%0d", first_cyc, n_cyc, NPIX + 2);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    exp_fc        = 0;
    rst           = 1'b1;
    cap_we_in     = 1'b0;
    cap_frame_end = 1'b0;
    stop          = 1'b0;
    snap_req      = 1'b0;
    pix.ready     = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    test_reset();
    test_cap_gating();
    test_frame_cnt_wrap();
    test_snapshot_stream();
    test_random_ready();
    test_same_cycle_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
